uart_transmit: RTL and testbench

- 8N1 UART transmitter. It is the transmit-side counterpart of the design's UART receive path.
- Accepts bytes from the CPU/IO side over a valid/ready handshake and serialises each one onto `tx`: start bit, 8 data bits LSB first, then stop bit(s).
- Contains its own bit-period counter, so no external divided clock is needed. Every flop is clocked by `clk`.
- Has a one-entry holding register, so the next byte can be queued while the current frame is shifting. Queued frames go out back-to-back with no idle gap.

---
 rtl/uart_transmit.sv | 123 ++++++++++++
 tb/tb_uart_transmit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - 8N1 UART transmitter with internal baud counter and one-entry holding register
module uart_transmit #(
    parameter int CLKS_PER_BIT = 625,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic              stop_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        hold_data;
    logic              hold_full;
    logic              bit_end;
    logic              frame_end;
    logic              accept;
    logic              load;

    assign bit_end    = (state != ST_IDLE) && (baud_cnt == BAUD_LAST);
    assign frame_end  = (state == ST_STOP) && bit_end && (stop_idx == STOP_LAST);
    // The holding register drains either from idle or straight out of the last stop cycle.
    assign load       = hold_full && ((state == ST_IDLE) || frame_end);
    assign data_ready = !hold_full;
    assign accept     = data_valid && data_ready;
    assign busy       = (state != ST_IDLE) || hold_full;
    assign done       = frame_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= data_in;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            shift_reg <= 8'h00;
        end else begin
            if ((state == ST_IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift_reg <= hold_data;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            state    <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_idx != STOP_LAST) begin
                            stop_idx <= 1'b1;
                        end else if (load) begin
                            shift_reg <= hold_data;
                            state     <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // tx lags the state by one cycle so the line is always a clean flop output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx <= 1'b1;
        end else begin
            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= shift_reg[bit_idx];
                default:  tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - scoreboard bench for uart_transmit (fast 4-clock instance and 625/2-stop instance)
module tb_uart_transmit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] data_in2;
    logic       data_valid2;
    logic       data_ready2;
    logic       tx2;
    logic       busy2;
    logic       done2;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    uart_transmit #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx(tx), .busy(busy), .done(done)
    );

    uart_transmit #(.CLKS_PER_BIT(625), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in2), .data_valid(data_valid2),
        .data_ready(data_ready2), .tx(tx2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_tx(input logic [7:0] b, input int off);
        if (off < 4) return 1'b0;
        if (off < 36) return b[(off - 4) / 4];
        return 1'b1;
    endfunction

    // Receive model: detects the start bit, samples mid-bit, pops the scoreboard at the stop bit.
    int         mon_cnt[2] = '{-1, -1};
    logic [7:0] mon_byte[2];
    always @(negedge clk) begin
        int   cpb;
        int   sb;
        int   j;
        logic t;
        for (int k = 0; k < 2; k++) begin
            cpb = (k == 1) ? 625 : 4;
            sb  = (k == 1) ? 2 : 1;
            t   = (k == 1) ? tx2 : tx;
            if (rst !== 1'b1) begin
                mon_cnt[k] = -1;
            end else if (mon_cnt[k] < 0) begin
                if (t === 1'b0) mon_cnt[k] = 0;
            end else begin
                mon_cnt[k]++;
                if (mon_cnt[k] % cpb == cpb / 2) begin
                    j = mon_cnt[k] / cpb;
                    if (j == 0) chk("rx_start_bit", t, 1'b0);
                    else if (j <= 8) mon_byte[k][j-1] = t;
                    else chk("rx_stop_bit", t, 1'b1);
                    if (j == 8 + sb) begin
                        if (exp_q.size() == 0) chk("rx_unexpected_frame", mon_byte[k], 0);
                        else chk((k == 1) ? "rx2_byte" : "rx_byte", mon_byte[k], exp_q.pop_front());
                    end
                end
                if (mon_cnt[k] == (9 + sb) * cpb - 1) mon_cnt[k] = -1;
            end
        end
    end

    task automatic trace_test(input string tag, input logic [7:0] b0, input logic [7:0] b1, input bit two);
        logic [99:0] g_tx, g_rdy, g_done, g_busy;
        logic [99:0] e_tx, e_rdy, e_done, e_busy;
        data_in    = b0;
        data_valid = 1'b1;
        exp_q.push_back(b0);
        for (int d = 0; d < 100; d++) begin
            @(negedge clk);
            g_tx[d]   = tx;
            g_rdy[d]  = data_ready;
            g_done[d] = done;
            g_busy[d] = busy;
            if (d == 0) begin
                data_in = b1;
                if (!two) data_valid = 1'b0;
            end
            if (d == 1 && two) exp_q.push_back(b1);
            if (d == 2 && two) begin
                data_valid = 1'b0;
                data_in    = 8'hEE;
            end
            if (d >= 2 && d < 42) e_tx[d] = frame_tx(b0, d - 2);
            else if (two && d >= 42 && d < 82) e_tx[d] = frame_tx(b1, d - 42);
            else e_tx[d] = 1'b1;
            e_done[d] = (d == 40) || (two && d == 80);
            e_busy[d] = (d <= (two ? 80 : 40));
            if (two) e_rdy[d] = (d == 1) || (d >= 41);
            else e_rdy[d] = (d != 0);
        end
        chk({tag, "_tx"}, g_tx, e_tx);
        chk({tag, "_done"}, g_done, e_done);
        chk({tag, "_busy"}, g_busy, e_busy);
        chk({tag, "_ready"}, g_rdy, e_rdy);
    endtask

    initial begin : main
        logic [7:0] bp_bytes[3];
        int         acc[3];
        int         n;
        bit         seen_low;
        bit         seen_done;
        bit         seen_busy;
        int         first_low;
        int         done_d;
        int         done_cnt;
        rst         = 1'b0;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        data_in2    = 8'h00;
        data_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", data_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst2_tx", tx2, 1'b1);
        chk("rst2_ready", data_ready2, 1'b1);
        seen_low = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        chk("idle_tx_high", seen_low, 1'b0);

        trace_test("a5", 8'hA5, 8'h3C, 1'b0);
        repeat (5) @(negedge clk);
        trace_test("b2b", 8'h00, 8'hFF, 1'b1);
        repeat (5) @(negedge clk);

        bp_bytes   = '{8'h11, 8'h22, 8'h33};
        data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = bp_bytes[i];
            n = 0;
            while (data_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("bp_ready_timeout", n < 200, 1'b1);
            acc[i] = cyc;
            exp_q.push_back(bp_bytes[i]);
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk("bp_gap_second", acc[1] - acc[0], 2);
        chk("bp_gap_third", acc[2] - acc[1], 40);
        repeat (100) @(negedge clk);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_idle", busy, 1'b0);

        data_in    = 8'h5A;
        data_valid = 1'b1;
        exp_q.push_back(8'h5A);
        for (int d = 0; d < 22; d++) begin
            @(negedge clk);
            if (d == 0) data_in = 8'h77;
            if (d == 1) exp_q.push_back(8'h77);
            if (d == 2) data_valid = 1'b0;
            if (d == 19) begin
                chk("mid_busy_before", busy, 1'b1);
                chk("mid_ready_before", data_ready, 1'b0);
                rst = 1'b0;
            end
            if (d == 20) begin
                chk("mid_rst_tx", tx, 1'b1);
                chk("mid_rst_busy", busy, 1'b0);
                chk("mid_rst_done", done, 1'b0);
                chk("mid_rst_ready", data_ready, 1'b1);
                exp_q.delete();
            end
            if (d == 21) rst = 1'b1;
        end
        seen_low  = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) seen_low = 1'b1;
            if (done !== 1'b0) seen_done = 1'b1;
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        chk("post_rst_no_tx", seen_low, 1'b0);
        chk("post_rst_no_done", seen_done, 1'b0);
        chk("post_rst_no_busy", seen_busy, 1'b0);

        data_in2    = 8'h3C;
        data_valid2 = 1'b1;
        exp_q.push_back(8'h3C);
        first_low = -1;
        done_d    = -1;
        done_cnt  = 0;
        for (int d = 0; d < 7000; d++) begin
            @(negedge clk);
            if (d == 0) begin
                data_valid2 = 1'b0;
                data_in2    = 8'hC3;
            end
            if (first_low < 0 && tx2 === 1'b0) first_low = d;
            if (done2 === 1'b1) begin
                done_d = d;
                done_cnt++;
            end
            if (d == 5626) chk("sb2_last_data", tx2, 1'b0);
            if (d == 5627) chk("sb2_stop_begin", tx2, 1'b1);
            if (d == 6875) chk("sb2_busy_end", busy2, 1'b1);
            if (d == 6876) begin
                chk("sb2_stop_end", tx2, 1'b1);
                chk("sb2_busy_fall", busy2, 1'b0);
            end
        end
        chk("sb2_start_latency", first_low, 2);
        chk("sb2_done_cycle", done_d, 6875);
        chk("sb2_done_count", done_cnt, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
